// File: rtl/dsp_mac_p.sv
// dsp_mac_p -- pipelined signed multiply-accumulate slice.
//
// Datapath: A*B -> optional M register -> PW+1-bit post-adder -> P register.
// C, OPMODE and the valid bit ride the same pipeline as A/B, so every result
// is built from its own operands. PCIN is used unregistered at the P stage.
// Latency from a sampled VALID_IN to VALID_OUT is AREG+MREG+1 cycles.
//
// Parameters: AW/BW signed operand widths, PW result width (>= AW+BW+1),
//   AREG input stages (0..2), MREG multiplier output stage (0..1).
// Ports:
//   CLK        rising-edge clock
//   RST        synchronous active-high reset, beats CE and VALID_IN
//   CE         clock enable; 0 freezes every pipeline register and P
//   VALID_IN   qualifies A, B, C, OPMODE
//   A, B       signed multiplier operands
//   C          signed addend
//   PCIN       cascade input, used as-is at the P stage
//   OPMODE     000 M, 001 P+M, 010 P-M, 011 C+M, 100 PCIN+M, 101 C-M,
//              110 P+C, 111 zero
//   P, PCOUT   result and its cascade copy
//   VALID_OUT  one-cycle strobe: P was updated by a valid op
//   OVF        signed overflow of the last valid P update
//
// Build option: define DSP_MAC_SAT_EN to clamp P on overflow instead of
// letting it wrap. OVF is reported either way.

module dsp_mac_p #(
  parameter int AW   = 18,
  parameter int BW   = 18,
  parameter int PW   = 48,
  parameter int AREG = 1,
  parameter int MREG = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CE,
  input  logic          VALID_IN,
  input  logic [AW-1:0] A,
  input  logic [BW-1:0] B,
  input  logic [PW-1:0] C,
  input  logic [PW-1:0] PCIN,
  input  logic [2:0]    OPMODE,
  output logic [PW-1:0] P,
  output logic [PW-1:0] PCOUT,
  output logic          VALID_OUT,
  output logic          OVF
);

  localparam int MW = AW + BW;

  localparam logic [2:0] OP_M      = 3'b000;
  localparam logic [2:0] OP_PPM    = 3'b001;
  localparam logic [2:0] OP_PMM    = 3'b010;
  localparam logic [2:0] OP_CPM    = 3'b011;
  localparam logic [2:0] OP_PCINPM = 3'b100;
  localparam logic [2:0] OP_CMM    = 3'b101;
  localparam logic [2:0] OP_PPC    = 3'b110;
  localparam logic [2:0] OP_ZERO   = 3'b111;

  typedef struct packed {
    logic          vld;
    logic [2:0]    op;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [PW-1:0] c;
  } req_t;

  typedef struct packed {
    logic          vld;
    logic [2:0]    op;
    logic [MW-1:0] m;
    logic [PW-1:0] c;
  } mreq_t;

  req_t  req_in, req_a;
  mreq_t mreq_d, mreq;

  assign req_in = '{vld: VALID_IN, op: OPMODE, a: A, b: B, c: C};

  // ---------------- input register stages ----------------
  // Operands are captured regardless of VALID_IN; the valid bit alone
  // decides whether they ever reach P.
  if (AREG == 0) begin : g_a0
    assign req_a = req_in;
  end else begin : g_areg
    req_t aq [1:AREG];
    always_ff @(posedge CLK) begin
      if (RST) begin
        for (int i = 1; i <= AREG; i++) aq[i] <= '0;
      end else if (CE) begin
        aq[1] <= req_in;
        for (int i = 2; i <= AREG; i++) aq[i] <= aq[i-1];
      end
    end
    assign req_a = aq[AREG];
  end

  // ---------------- multiplier ----------------
  logic signed [MW-1:0] prod;
  assign prod = $signed(req_a.a) * $signed(req_a.b);

  assign mreq_d = '{vld: req_a.vld, op: req_a.op, m: prod, c: req_a.c};

  if (MREG == 0) begin : g_m0
    assign mreq = mreq_d;
  end else begin : g_mreg
    always_ff @(posedge CLK) begin
      if (RST)     mreq <= '0;
      else if (CE) mreq <= mreq_d;
    end
  end

  // ---------------- post-adder ----------------
  // One guard bit above PW: any result whose top two bits differ cannot be
  // represented in PW signed bits.
  logic signed [PW:0] mx, px, cx, pcx, sum;
  logic [PW-1:0] p_nxt;
  logic          ovf_nxt;

  assign mx  = {{(PW+1-MW){mreq.m[MW-1]}}, mreq.m};
  assign px  = {P[PW-1], P};
  assign cx  = {mreq.c[PW-1], mreq.c};
  assign pcx = {PCIN[PW-1], PCIN};

  always_comb begin
    sum = '0;
    unique case (mreq.op)
      OP_M:      sum = mx;
      OP_PPM:    sum = px + mx;
      OP_PMM:    sum = px - mx;
      OP_CPM:    sum = cx + mx;
      OP_PCINPM: sum = pcx + mx;
      OP_CMM:    sum = cx - mx;
      OP_PPC:    sum = px + cx;
      OP_ZERO:   sum = '0;
      default:   sum = '0;
    endcase
  end

  assign ovf_nxt = sum[PW] ^ sum[PW-1];

`ifdef DSP_MAC_SAT_EN
  // Clamp toward the sign of the true (PW+1-bit) result.
  always_comb begin
    p_nxt = sum[PW-1:0];
    if (ovf_nxt) p_nxt = sum[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
  end
`else
  assign p_nxt = sum[PW-1:0];
`endif

  // ---------------- P stage ----------------
  // VALID_OUT is not frozen by CE: it is a strobe and drops whenever the
  // previous edge did not perform a valid update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      P         <= '0;
      OVF       <= 1'b0;
      VALID_OUT <= 1'b0;
    end else begin
      VALID_OUT <= CE & mreq.vld;
      if (CE && mreq.vld) begin
        P   <= p_nxt;
        OVF <= ovf_nxt;
      end
    end
  end

  assign PCOUT = P;

endmodule

// File: tb/tb_dsp_mac_p.sv
// Directed bench for dsp_mac_p at default parameters (AW=BW=18, PW=48,
// AREG=MREG=1, latency 3). Single ops come from a vector table whose P
// values chain from one entry to the next; streaming, clock-enable stalls
// and mid-stream reset are hand-written per-cycle sequences.

module tb_dsp_mac_p;

  logic               CLK = 1'b0;
  logic               RST, CE, VALID_IN;
  logic signed [17:0] A, B;
  logic [47:0]        C, PCIN;
  logic [2:0]         OPMODE;
  logic [47:0]        P, PCOUT;
  logic               VALID_OUT, OVF;

  int nchk = 0;
  int nerr = 0;

  dsp_mac_p dut (
    .CLK(CLK), .RST(RST), .CE(CE), .VALID_IN(VALID_IN),
    .A(A), .B(B), .C(C), .PCIN(PCIN), .OPMODE(OPMODE),
    .P(P), .PCOUT(PCOUT), .VALID_OUT(VALID_OUT), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic signed [17:0] a, b;
    logic [47:0]        c, pcin;
    logic [2:0]         op;
    logic [47:0]        ep;
    logic               eovf;
  } vec_t;

  vec_t tv [13];

  // Per-edge expectations for the clock-enable stall (edges 1..11).
  int ce_ep [11] = '{0, 0, 5, 5, 5, 10, 15, 20, 25, 30, 30};
  int ce_vo [11] = '{0, 0, 1, 0, 0, 1, 1, 1, 1, 1, 0};
  // Per-edge expectations for reset during a stream (edges 1..9).
  int rs_ep [9]  = '{0, 0, 4, 0, 0, 0, 4, 8, 8};
  int rs_vo [9]  = '{0, 0, 1, 0, 0, 0, 1, 1, 0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance one clock; drive and sample 1 ns after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    VALID_IN = 1'b0;
    A        = 18'($urandom);
    B        = 18'($urandom);
    C        = {16'($urandom), 32'($urandom)};
    PCIN     = {16'($urandom), 32'($urandom)};
    OPMODE   = 3'($urandom);
  endtask

  task automatic do_rst();
    RST = 1'b1; CE = 1'b1; idle_inputs();
    step();
    RST = 1'b0;
  endtask

  initial begin
    int lat;

    // P chains through the table: each entry starts from the previous P.
    tv[0]  = '{a: 18'sd20, b: 18'sd10, c: 48'd999, pcin: 48'd12345, op: 3'b000, ep: 48'd200, eovf: 1'b0};
    tv[1]  = '{a: 18'sd3,  b: 18'sd4,  c: 48'd999, pcin: 48'd12345, op: 3'b001, ep: 48'd212, eovf: 1'b0};
    tv[2]  = '{a: 18'sd2,  b: 18'sd6,  c: 48'd999, pcin: 48'd12345, op: 3'b010, ep: 48'd200, eovf: 1'b0};
    tv[3]  = '{a: -18'sd5, b: 18'sd6,  c: 48'd100, pcin: 48'd12345, op: 3'b011, ep: 48'd70,  eovf: 1'b0};
    tv[4]  = '{a: -18'sd5, b: 18'sd6,  c: 48'd100, pcin: 48'd12345, op: 3'b101, ep: 48'd130, eovf: 1'b0};
    tv[5]  = '{a: 18'sd7,  b: 18'sd7,  c: -48'sd30, pcin: 48'd12345, op: 3'b110, ep: 48'd100, eovf: 1'b0};
    tv[6]  = '{a: -18'sd3, b: 18'sd3,  c: 48'd999, pcin: 48'd1000,  op: 3'b100, ep: 48'd991, eovf: 1'b0};
    tv[7]  = '{a: 18'sd9,  b: 18'sd9,  c: 48'd999, pcin: 48'd12345, op: 3'b111, ep: 48'd0,   eovf: 1'b0};
`ifdef DSP_MAC_SAT_EN
    tv[8]  = '{a: 18'sd1,  b: 18'sd1,  c: 48'h7FFF_FFFF_FFFF, pcin: 48'd0, op: 3'b011, ep: 48'h7FFF_FFFF_FFFF, eovf: 1'b1};
`else
    tv[8]  = '{a: 18'sd1,  b: 18'sd1,  c: 48'h7FFF_FFFF_FFFF, pcin: 48'd0, op: 3'b011, ep: 48'h8000_0000_0000, eovf: 1'b1};
`endif
    tv[9]  = '{a: -18'sd131072, b: -18'sd131072, c: 48'd5, pcin: 48'd0, op: 3'b000, ep: 48'd17179869184, eovf: 1'b0};
`ifdef DSP_MAC_SAT_EN
    tv[10] = '{a: -18'sd1, b: 18'sd1, c: 48'h8000_0000_0000, pcin: 48'd0, op: 3'b011, ep: 48'h8000_0000_0000, eovf: 1'b1};
    tv[11] = '{a: -18'sd1, b: 18'sd1, c: 48'd0, pcin: 48'd0, op: 3'b010, ep: 48'h8000_0000_0001, eovf: 1'b0};
`else
    tv[10] = '{a: -18'sd1, b: 18'sd1, c: 48'h8000_0000_0000, pcin: 48'd0, op: 3'b011, ep: 48'h7FFF_FFFF_FFFF, eovf: 1'b1};
    tv[11] = '{a: -18'sd1, b: 18'sd1, c: 48'd0, pcin: 48'd0, op: 3'b010, ep: 48'h8000_0000_0000, eovf: 1'b1};
`endif
    tv[12] = '{a: 18'sd1,  b: 18'sd1,  c: 48'd0, pcin: 48'd0, op: 3'b111, ep: 48'd0, eovf: 1'b0};

    // ---- reset with junk on every input, CE random ----
    RST = 1'b1;
    idle_inputs();
    VALID_IN = 1'b1;
    CE = 1'($urandom);
    step();
    CE = 1'($urandom);
    step();
    chk("rst_p",     64'(P),         64'd0);
    chk("rst_pcout", 64'(PCOUT),     64'd0);
    chk("rst_vout",  64'(VALID_OUT), 64'd0);
    chk("rst_ovf",   64'(OVF),       64'd0);
    RST = 1'b0;
    CE  = 1'b1;
    idle_inputs();
    step();

    // ---- single ops from the table ----
    for (int i = 0; i < 13; i++) begin
      VALID_IN = 1'b1;
      A = tv[i].a; B = tv[i].b; C = tv[i].c; PCIN = tv[i].pcin; OPMODE = tv[i].op;
      step();
      idle_inputs();
      lat = 1;
      while (!VALID_OUT && lat < 10) begin
        // PCIN is live at the P stage, so hold it for cascade ops
        PCIN = tv[i].pcin;
        step();
        lat++;
      end
      chk($sformatf("v%0d_lat", i),   64'(lat),   64'd3);
      chk($sformatf("v%0d_p", i),     64'(P),     64'(tv[i].ep));
      chk($sformatf("v%0d_pcout", i), 64'(PCOUT), 64'(tv[i].ep));
      chk($sformatf("v%0d_ovf", i),   64'(OVF),   64'(tv[i].eovf));
      step();
      chk($sformatf("v%0d_pulse", i), 64'(VALID_OUT), 64'd0);
      chk($sformatf("v%0d_hold", i),  64'(P),         64'(tv[i].ep));
    end

    // ---- back-to-back accumulate: 3*4 four times ----
    do_rst();
    for (int i = 0; i < 8; i++) begin
      VALID_IN = (i < 4);
      A = 18'sd3; B = 18'sd4; C = 48'd77; OPMODE = 3'b001;
      step();
      if (i >= 2 && i <= 5) begin
        chk($sformatf("acc_e%0d_vo", i+1), 64'(VALID_OUT), 64'd1);
        chk($sformatf("acc_e%0d_p", i+1),  64'(P),         64'(12 * (i - 1)));
      end else begin
        chk($sformatf("acc_e%0d_vo", i+1), 64'(VALID_OUT), 64'd0);
      end
    end
    chk("acc_final", 64'(P), 64'd48);

    // ---- CE low on edges 4 and 5 mid-stream; junk offered while stalled ----
    do_rst();
    for (int e = 1; e <= 11; e++) begin
      CE       = !(e == 4 || e == 5);
      VALID_IN = (e <= 8);
      A        = CE ? 18'sd1 : 18'sd100;
      B        = 18'sd5;
      OPMODE   = 3'b001;
      step();
      chk($sformatf("ce_e%0d_vo", e), 64'(VALID_OUT), 64'(ce_vo[e-1]));
      chk($sformatf("ce_e%0d_p", e),  64'(P),         64'(ce_ep[e-1]));
    end
    CE = 1'b1;

    // ---- reset (with CE low) during a stream of 2*2 accumulates ----
    do_rst();
    for (int e = 1; e <= 9; e++) begin
      RST      = (e == 4);
      CE       = (e != 4);
      VALID_IN = (e <= 6);
      A = 18'sd2; B = 18'sd2; OPMODE = 3'b001;
      step();
      chk($sformatf("rs_e%0d_vo", e), 64'(VALID_OUT), 64'(rs_vo[e-1]));
      chk($sformatf("rs_e%0d_p", e),  64'(P),         64'(rs_ep[e-1]));
    end
    RST = 1'b0; CE = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  // Hard stop in case a sequence above stops advancing.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
